// File: rtl/reg_file_mp.sv
// Register file with general and special banks, two prioritised write ports, bulk special
// write, optional write-to-read bypass and a sequential post-reset initialisation engine.
module reg_file_mp #(
  parameter int ARCH_BITS    = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_SPECIAL  = 5,
  parameter int REG_IDX_BITS = 5,
  parameter int BYPASS       = 1,
  parameter int PRIV_IDX     = 4,
  // Slot 0 is the rightmost word: special3 = 32'h11111111, special4 = 32'h00001000.
  parameter logic [NUM_SPECIAL*ARCH_BITS-1:0] SPECIAL_INIT =
    {32'h00001000, 32'h11111111, 32'h0, 32'h0, 32'h0}
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [REG_IDX_BITS-1:0]          src1,
  input  logic [REG_IDX_BITS-1:0]          src2,
  input  logic                             special1,
  input  logic                             special2,
  input  logic [REG_IDX_BITS-1:0]          dstA,
  input  logic                             specialDstA,
  input  logic [ARCH_BITS-1:0]             wDataA,
  input  logic                             writeEnableA,
  input  logic [REG_IDX_BITS-1:0]          dstB,
  input  logic                             specialDstB,
  input  logic [ARCH_BITS-1:0]             wDataB,
  input  logic                             writeEnableB,
  input  logic [NUM_SPECIAL*ARCH_BITS-1:0] rmwData,
  input  logic [NUM_SPECIAL-1:0]           rmWriteMask,
  output logic [ARCH_BITS-1:0]             data1,
  output logic [ARCH_BITS-1:0]             data2,
  output logic [ARCH_BITS-1:0]             dataPriv,
  output logic                             ready,
  output logic [0:0]                       dbg_state
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [REG_IDX_BITS-1:0] init_cnt_q, init_cnt_d;
  logic [ARCH_BITS-1:0]    gen_q  [NUM_REGS];
  logic [ARCH_BITS-1:0]    gen_d  [NUM_REGS];
  logic [ARCH_BITS-1:0]    spec_q [NUM_SPECIAL];
  logic [ARCH_BITS-1:0]    spec_d [NUM_SPECIAL];
  logic [ARCH_BITS-1:0]    rd1, rd2, rd_priv;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + REG_IDX_BITS'(1);
      if (32'(init_cnt_q) == NUM_REGS - 1) begin
        state_d    = ST_RUN;
        init_cnt_d = '0;
      end
    end
  end

  // Next contents; out-of-range indices simply match no loop iteration.
  always_comb begin
    gen_d  = gen_q;
    spec_d = spec_q;
    if (state_q == ST_INIT) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (32'(init_cnt_q) == i) gen_d[i] = ARCH_BITS'(init_cnt_q);
      end
      if (init_cnt_q == '0) begin
        for (int k = 0; k < NUM_SPECIAL; k++) begin
          spec_d[k] = SPECIAL_INIT[k*ARCH_BITS +: ARCH_BITS];
        end
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (writeEnableA && !specialDstA && 32'(dstA) == i)      gen_d[i] = wDataA;
        else if (writeEnableB && !specialDstB && 32'(dstB) == i) gen_d[i] = wDataB;
      end
      for (int k = 0; k < NUM_SPECIAL; k++) begin
        if (rmWriteMask[k])                                     spec_d[k] = rmwData[k*ARCH_BITS +: ARCH_BITS];
        else if (writeEnableA && specialDstA && 32'(dstA) == k) spec_d[k] = wDataA;
        else if (writeEnableB && specialDstB && 32'(dstB) == k) spec_d[k] = wDataB;
      end
    end
  end

  // In RUN the next-state arrays hold exactly the winning writes, so they double as bypass.
  always_comb begin
    rd1     = '0;
    rd2     = '0;
    rd_priv = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!special1 && 32'(src1) == i) rd1 = (BYPASS != 0) ? gen_d[i] : gen_q[i];
      if (!special2 && 32'(src2) == i) rd2 = (BYPASS != 0) ? gen_d[i] : gen_q[i];
    end
    for (int k = 0; k < NUM_SPECIAL; k++) begin
      if (special1 && 32'(src1) == k) rd1 = (BYPASS != 0) ? spec_d[k] : spec_q[k];
      if (special2 && 32'(src2) == k) rd2 = (BYPASS != 0) ? spec_d[k] : spec_q[k];
      if (k == PRIV_IDX)              rd_priv = (BYPASS != 0) ? spec_d[k] : spec_q[k];
    end
  end

  assign ready     = (state_q == ST_RUN);
  assign data1     = ready ? rd1 : '0;
  assign data2     = ready ? rd2 : '0;
  assign dataPriv  = ready ? rd_priv : '0;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Storage has no reset; INIT rewrites every register.
  always_ff @(posedge clk) begin
    gen_q  <= gen_d;
    spec_q <= spec_d;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a default build (BYPASS=1, 32 regs) and an alternate build
// (BYPASS=0, 24 regs) share stimulus and are checked against an array-based reference.
module tb_reg_file_mp;
  localparam int AW = 32;
  localparam int NS = 5;
  localparam int IW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [IW-1:0]   src1, src2, dstA, dstB;
  logic            special1, special2, specialDstA, specialDstB;
  logic            writeEnableA, writeEnableB;
  logic [AW-1:0]   wDataA, wDataB;
  logic [NS*AW-1:0] rmwData;
  logic [NS-1:0]   rmWriteMask;

  logic [AW-1:0] d1 [2];
  logic [AW-1:0] d2 [2];
  logic [AW-1:0] dp [2];
  logic          rdy [2];
  logic [0:0]    dbg [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state per build: 0 = default, 1 = alternate.
  int          nregs [2] = '{32, 24};
  int          byp   [2] = '{1, 0};
  logic [AW-1:0] sp_init [NS] = '{32'h0, 32'h0, 32'h0, 32'h11111111, 32'h00001000};
  logic [AW-1:0] m_gen   [2][32];
  logic [AW-1:0] m_spec  [2][NS];
  logic [AW-1:0] nx_gen  [2][32];
  logic [AW-1:0] nx_spec [2][NS];
  int            m_cnt   [2] = '{0, 0};
  bit            m_ready [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  reg_file_mp #(.BYPASS(1)) u_main (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .special1(special1), .special2(special2),
    .dstA(dstA), .specialDstA(specialDstA), .wDataA(wDataA), .writeEnableA(writeEnableA),
    .dstB(dstB), .specialDstB(specialDstB), .wDataB(wDataB), .writeEnableB(writeEnableB),
    .rmwData(rmwData), .rmWriteMask(rmWriteMask), .data1(d1[0]), .data2(d2[0]),
    .dataPriv(dp[0]), .ready(rdy[0]), .dbg_state(dbg[0])
  );

  reg_file_mp #(.NUM_REGS(24), .BYPASS(0)) u_alt (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .special1(special1), .special2(special2),
    .dstA(dstA), .specialDstA(specialDstA), .wDataA(wDataA), .writeEnableA(writeEnableA),
    .dstB(dstB), .specialDstB(specialDstB), .wDataB(wDataB), .writeEnableB(writeEnableB),
    .rmwData(rmwData), .rmWriteMask(rmWriteMask), .data1(d1[1]), .data2(d2[1]),
    .dataPriv(dp[1]), .ready(rdy[1]), .dbg_state(dbg[1])
  );

  task automatic check_eq(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic apply_write(input int c, input logic en, input logic sp,
                             input logic [IW-1:0] dst, input logic [AW-1:0] data);
    int idx;
    idx = int'(dst);
    if (!en) return;
    if (sp) begin
      if (idx < NS) nx_spec[c][idx] = data;
    end else if (idx < nregs[c]) begin
      nx_gen[c][idx] = data;
    end
  endtask

  // Later writes overwrite earlier ones, so apply lowest priority first.
  task automatic model_predict();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 32; i++) nx_gen[c][i] = m_gen[c][i];
      for (int k = 0; k < NS; k++) nx_spec[c][k] = m_spec[c][k];
      if (m_ready[c]) begin
        apply_write(c, writeEnableB, specialDstB, dstB, wDataB);
        apply_write(c, writeEnableA, specialDstA, dstA, wDataA);
        for (int k = 0; k < NS; k++)
          if (rmWriteMask[k]) nx_spec[c][k] = rmwData[k*AW +: AW];
      end
    end
  endtask

  task automatic model_commit();
    for (int c = 0; c < 2; c++) begin
      if (!rst) continue;
      if (m_ready[c]) begin
        for (int i = 0; i < 32; i++) m_gen[c][i] = nx_gen[c][i];
        for (int k = 0; k < NS; k++) m_spec[c][k] = nx_spec[c][k];
      end else begin
        m_cnt[c]++;
        if (m_cnt[c] == nregs[c]) begin
          m_ready[c] = 1'b1;
          for (int i = 0; i < 32; i++) m_gen[c][i] = AW'(i);
          for (int k = 0; k < NS; k++) m_spec[c][k] = sp_init[k];
        end
      end
    end
  endtask

  function automatic logic [AW-1:0] exp_read(input int c, input logic sp, input logic [IW-1:0] idx);
    int i;
    i = int'(idx);
    if (!m_ready[c]) return '0;
    if (sp) begin
      if (i >= NS) return '0;
      return (byp[c] != 0) ? nx_spec[c][i] : m_spec[c][i];
    end
    if (i >= nregs[c]) return '0;
    return (byp[c] != 0) ? nx_gen[c][i] : m_gen[c][i];
  endfunction

  // Called just after a posedge with inputs already driven; checks, then clocks once.
  task automatic step();
    model_predict();
    #2;
    for (int c = 0; c < 2; c++) begin
      check_eq($sformatf("c%0d_ready", c), {31'b0, rdy[c]}, {31'b0, m_ready[c]});
      check_eq($sformatf("c%0d_data1 s%0d[%0d]", c, special1, src1), d1[c], exp_read(c, special1, src1));
      check_eq($sformatf("c%0d_data2 s%0d[%0d]", c, special2, src2), d2[c], exp_read(c, special2, src2));
      check_eq($sformatf("c%0d_dataPriv", c), dp[c], exp_read(c, 1'b1, 5'd4));
    end
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic clear_inputs();
    src1 = '0; src2 = '0; special1 = 1'b0; special2 = 1'b0;
    dstA = '0; dstB = '0; specialDstA = 1'b0; specialDstB = 1'b0;
    wDataA = '0; wDataB = '0; writeEnableA = 1'b0; writeEnableB = 1'b0;
    rmwData = '0; rmWriteMask = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      m_ready[c] = 1'b0;
      m_cnt[c]   = 0;
    end
    #1;
    for (int c = 0; c < 2; c++)
      check_eq($sformatf("c%0d_ready_in_reset", c), {31'b0, rdy[c]}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic random_inputs();
    special1     = 1'($urandom_range(0, 1));
    special2     = 1'($urandom_range(0, 1));
    src1         = special1 ? IW'($urandom_range(0, 6)) : IW'($urandom_range(0, 31));
    src2         = special2 ? IW'($urandom_range(0, 6)) : IW'($urandom_range(0, 31));
    specialDstA  = 1'($urandom_range(0, 3) == 0);
    specialDstB  = 1'($urandom_range(0, 3) == 0);
    dstA         = specialDstA ? IW'($urandom_range(0, 6)) : IW'($urandom_range(0, 31));
    dstB         = ($urandom_range(0, 3) == 0) ? dstA :
                   (specialDstB ? IW'($urandom_range(0, 6)) : IW'($urandom_range(0, 31)));
    writeEnableA = 1'($urandom_range(0, 1));
    writeEnableB = 1'($urandom_range(0, 1));
    wDataA       = $urandom;
    wDataB       = $urandom;
    rmWriteMask  = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
    for (int k = 0; k < NS; k++) rmwData[k*AW +: AW] = $urandom;
  endtask

  initial begin
    clear_inputs();
    do_reset();

    // Initialisation window, then defaults.
    src1 = 5'd7; src2 = 5'd31;
    repeat (33) step();
    special1 = 1'b1; src1 = 5'd3;
    step();
    clear_inputs();

    // Port A beats port B on the same register; different registers both commit.
    writeEnableA = 1'b1; dstA = 5'd5; wDataA = 32'hAAAA0000;
    writeEnableB = 1'b1; dstB = 5'd5; wDataB = 32'hBBBB0000;
    src1 = 5'd5;
    step();
    dstB = 5'd6;
    step();
    clear_inputs();
    src1 = 5'd5; src2 = 5'd6;
    step();

    // Bulk mask beats port A on special 4.
    rmWriteMask = 5'b10001;
    rmwData[0*AW +: AW] = 32'h1;
    rmwData[4*AW +: AW] = 32'h2;
    writeEnableA = 1'b1; specialDstA = 1'b1; dstA = 5'd4; wDataA = 32'h9;
    special1 = 1'b1; src1 = 5'd0;
    step();
    clear_inputs();
    special1 = 1'b1; special2 = 1'b1;
    for (int k = 0; k < NS; k++) begin
      src1 = IW'(k); src2 = IW'((k + 1) % NS);
      step();
    end
    clear_inputs();

    // Same-cycle bypass versus stored value.
    writeEnableA = 1'b1; dstA = 5'd9; wDataA = 32'hDEAD; src1 = 5'd9;
    step();
    writeEnableA = 1'b0;
    step();

    // Out-of-range writes and reads.
    writeEnableA = 1'b1; specialDstA = 1'b1; dstA = 5'd6; wDataA = 32'h5;
    special1 = 1'b1; src1 = 5'd6;
    step();
    clear_inputs();
    writeEnableA = 1'b1; dstA = 5'd30; wDataA = 32'h1234; src1 = 5'd30; src2 = 5'd23;
    step();
    writeEnableA = 1'b0;
    step();

    repeat (400) begin
      random_inputs();
      step();
    end

    // Reset from RUN, then again partway through INIT.
    clear_inputs();
    do_reset();
    repeat (10) step();
    do_reset();
    writeEnableA = 1'b1; dstA = 5'd3; wDataA = 32'hFFFF; src1 = 5'd3; src2 = 5'd9;
    repeat (4) step();
    writeEnableA = 1'b0;
    repeat (30) step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
